// File: rtl/cpu_pkg.sv
// Shared types for the accumulator processor control unit: opcodes, sequencer states, strobe bundle.
// The HALT state exists only when SEQ_HALT_EN is defined.
package cpu_pkg;

  localparam int unsigned WORD_W_DEF = 8;
  localparam int unsigned OP_W_DEF   = 3;
  localparam int unsigned STATE_W    = 3;

  // Opcode values are shared with the assembler's opcode header; keep them fixed.
  typedef enum logic [OP_W_DEF-1:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_BNE   = 3'd4,
    OP_XOR   = 3'd5,
    OP_NOP   = 3'd6,
    OP_HALT  = 3'd7
  } opcode_t;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH_A = 3'd0,
    S_FETCH_D = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC_RD = 3'd3,
    S_EXEC_WR = 3'd4
`ifdef SEQ_HALT_EN
    , S_HALT  = 3'd5
`endif
  } state_t;

  typedef struct packed {
    logic acc_bus;
    logic load_acc;
    logic pc_bus;
    logic load_pc;
    logic inc_pc;
    logic load_ir;
    logic addr_bus;
    logic alu_acc;
    logic alu_add;
    logic alu_sub;
    logic alu_xor;
    logic load_mar;
    logic load_mdr;
    logic mdr_bus;
    logic cs;
    logic r_nw;
    logic instr_done;
  } ctrl_t;

  // Quiescent strobe set: nothing driven, memory left in read mode.
  localparam ctrl_t CTRL_IDLE = '{r_nw: 1'b1, default: 1'b0};

endpackage

// File: rtl/seq_wait_counter.sv
// Memory wait-state counter: counts cycles within a memory state, flags the final one.
module seq_wait_counter
#(
  parameter int unsigned WAIT_STATES = 0
)
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_W'(WAIT_STATES));

endmodule

// File: rtl/cpu_sequencer.sv
// Control-unit FSM sequencing fetch/decode/execute and driving all sysbus strobes.
// Define SEQ_HALT_EN to make opcode 7 a HALT (exit by reset only); otherwise it is a NOP.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned WORD_W      = WORD_W_DEF,
  parameter int unsigned OP_W        = OP_W_DEF,
  parameter int unsigned WAIT_STATES = 0
)
(
  input  logic            clock,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  output logic            ACC_bus,
  output logic            load_ACC,
  output logic            PC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_IR,
  output logic            Addr_bus,
  output logic            ALU_ACC,
  output logic            ALU_add,
  output logic            ALU_sub,
  output logic            ALU_xor,
  output logic            load_MAR,
  output logic            load_MDR,
  output logic            MDR_bus,
  output logic            CS,
  output logic            R_NW,
  output logic            instr_done
);

  if (OP_W > WORD_W) begin : g_bad_op_w
    $error("OP_W must not exceed WORD_W");
  end

  state_t state_q, state_d;
  ctrl_t  ctrl, ctrl_c;
  logic   mem_state;
  logic   wait_last;

  seq_wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait (
    .clock  (clock),
    .reset  (reset),
    .clear  (~mem_state | wait_last),
    .enable (ctrl.cs),
    .last   (wait_last)
  );

  // Next state and strobes from state, opcode, Z flag and wait counter.
  always_comb begin
    state_d   = state_q;
    ctrl      = CTRL_IDLE;
    mem_state = 1'b0;
    case (state_q)
      S_FETCH_A: begin
        ctrl.pc_bus   = 1'b1;
        ctrl.load_mar = 1'b1;
        ctrl.inc_pc   = 1'b1;
        ctrl.load_pc  = 1'b1;
        state_d       = S_FETCH_D;
      end
      S_FETCH_D: begin
        mem_state = 1'b1;
        ctrl.cs   = 1'b1;
        if (wait_last) begin
          ctrl.mdr_bus = 1'b1;
          ctrl.load_ir = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.addr_bus = 1'b1;
        ctrl.load_mar = 1'b1;
        case (op)
          OP_W'(OP_LOAD), OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_XOR): state_d = S_EXEC_RD;
          OP_W'(OP_STORE): state_d = S_EXEC_WR;
          OP_W'(OP_BNE): begin
            ctrl.load_pc    = ~z_flag;
            ctrl.instr_done = 1'b1;
            state_d         = S_FETCH_A;
          end
`ifdef SEQ_HALT_EN
          OP_W'(OP_HALT): begin
            ctrl.instr_done = 1'b1;
            state_d         = S_HALT;
          end
`endif
          default: begin
            ctrl.instr_done = 1'b1;
            state_d         = S_FETCH_A;
          end
        endcase
      end
      S_EXEC_RD: begin
        mem_state    = 1'b1;
        ctrl.cs      = 1'b1;
        ctrl.alu_add = (op == OP_W'(OP_ADD));
        ctrl.alu_sub = (op == OP_W'(OP_SUB));
        ctrl.alu_xor = (op == OP_W'(OP_XOR));
        ctrl.alu_acc = ctrl.alu_add | ctrl.alu_sub | ctrl.alu_xor;
        if (wait_last) begin
          ctrl.mdr_bus    = 1'b1;
          ctrl.load_acc   = 1'b1;
          ctrl.instr_done = 1'b1;
          state_d         = S_FETCH_A;
        end
      end
      S_EXEC_WR: begin
        mem_state     = 1'b1;
        ctrl.acc_bus  = 1'b1;
        ctrl.load_mdr = 1'b1;
        ctrl.cs       = 1'b1;
        ctrl.r_nw     = 1'b0;
        if (wait_last) begin
          ctrl.instr_done = 1'b1;
          state_d         = S_FETCH_A;
        end
      end
`ifdef SEQ_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_FETCH_A;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset silences the bus immediately, independent of the state register.
  assign ctrl_c = reset ? CTRL_IDLE : ctrl;

  assign ACC_bus    = ctrl_c.acc_bus;
  assign load_ACC   = ctrl_c.load_acc;
  assign PC_bus     = ctrl_c.pc_bus;
  assign load_PC    = ctrl_c.load_pc;
  assign INC_PC     = ctrl_c.inc_pc;
  assign load_IR    = ctrl_c.load_ir;
  assign Addr_bus   = ctrl_c.addr_bus;
  assign ALU_ACC    = ctrl_c.alu_acc;
  assign ALU_add    = ctrl_c.alu_add;
  assign ALU_sub    = ctrl_c.alu_sub;
  assign ALU_xor    = ctrl_c.alu_xor;
  assign load_MAR   = ctrl_c.load_mar;
  assign load_MDR   = ctrl_c.load_mdr;
  assign MDR_bus    = ctrl_c.mdr_bus;
  assign CS         = ctrl_c.cs;
  assign R_NW       = ctrl_c.r_nw;
  assign instr_done = ctrl_c.instr_done;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: three instances (WAIT_STATES 0,1,2) share stimulus.
// Each cycle the full 17-bit strobe vector is compared against hand-built expectations.
module tb_cpu_sequencer;

  localparam logic [16:0] ACC_BUS  = 17'd1 << 16;
  localparam logic [16:0] LOAD_ACC = 17'd1 << 15;
  localparam logic [16:0] PC_BUS   = 17'd1 << 14;
  localparam logic [16:0] LOAD_PC  = 17'd1 << 13;
  localparam logic [16:0] INC_PC   = 17'd1 << 12;
  localparam logic [16:0] LOAD_IR  = 17'd1 << 11;
  localparam logic [16:0] ADDR_BUS = 17'd1 << 10;
  localparam logic [16:0] ALU_ACC  = 17'd1 << 9;
  localparam logic [16:0] ALU_ADD  = 17'd1 << 8;
  localparam logic [16:0] ALU_SUB  = 17'd1 << 7;
  localparam logic [16:0] ALU_XOR  = 17'd1 << 6;
  localparam logic [16:0] LOAD_MAR = 17'd1 << 5;
  localparam logic [16:0] LOAD_MDR = 17'd1 << 4;
  localparam logic [16:0] MDR_BUS  = 17'd1 << 3;
  localparam logic [16:0] CS       = 17'd1 << 2;
  localparam logic [16:0] R_NW     = 17'd1 << 1;
  localparam logic [16:0] DONE     = 17'd1;

  localparam logic [16:0] IDLE = R_NW;
  localparam logic [16:0] FA   = PC_BUS | LOAD_MAR | INC_PC | LOAD_PC | R_NW;
  localparam logic [16:0] FD   = CS | R_NW;
  localparam logic [16:0] FD_L = CS | R_NW | MDR_BUS | LOAD_IR;
  localparam logic [16:0] DEC  = ADDR_BUS | LOAD_MAR | R_NW;
  localparam logic [16:0] RD   = CS | R_NW;
  localparam logic [16:0] RD_L = CS | R_NW | MDR_BUS | LOAD_ACC | DONE;
  localparam logic [16:0] WR   = ACC_BUS | LOAD_MDR | CS;
  localparam logic [16:0] WR_L = ACC_BUS | LOAD_MDR | CS | DONE;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_BNE   = 3'd4;
  localparam logic [2:0] OP_XOR   = 3'd5;
  localparam logic [2:0] OP_SEVEN = 3'd7;

  logic       clock;
  logic       reset;
  logic [2:0] op;
  logic       z_flag;
  wire [16:0] o [3];

  int nvec = 0;
  int nmis = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cpu_sequencer #(.WORD_W(8), .OP_W(3), .WAIT_STATES(g)) u_dut (
      .clock      (clock),
      .reset      (reset),
      .op         (op),
      .z_flag     (z_flag),
      .ACC_bus    (o[g][16]),
      .load_ACC   (o[g][15]),
      .PC_bus     (o[g][14]),
      .load_PC    (o[g][13]),
      .INC_PC     (o[g][12]),
      .load_IR    (o[g][11]),
      .Addr_bus   (o[g][10]),
      .ALU_ACC    (o[g][9]),
      .ALU_add    (o[g][8]),
      .ALU_sub    (o[g][7]),
      .ALU_xor    (o[g][6]),
      .load_MAR   (o[g][5]),
      .load_MDR   (o[g][4]),
      .MDR_bus    (o[g][3]),
      .CS         (o[g][2]),
      .R_NW       (o[g][1]),
      .instr_done (o[g][0])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse reset for one cycle with new inputs; returns at the negedge where reset falls.
  task automatic restart(input logic [2:0] opc, input logic z);
    @(negedge clock);
    reset  = 1'b1;
    op     = opc;
    z_flag = z;
    @(negedge clock);
    reset  = 1'b0;
  endtask

  task automatic test_reset;
    logic [16:0] exp_q[$];
    reset = 1'b1; op = OP_STORE; z_flag = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    for (int g = 0; g < 3; g++) begin
      nvec++;
      if (o[g] !== IDLE) begin
        nmis++;
        $display("FAIL reset_init w%0d: got %h want %h", g, o[g], IDLE);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    exp_q = '{FA, FD_L, DEC, WR_L};
    foreach (exp_q[i]) begin
      if (i != 0) @(negedge clock);
      #1;
      if (i == 3) begin
        reset = 1'b1;
        #1;
        exp_q[i] = IDLE;
      end
      nvec++;
      if (o[0] !== exp_q[i]) begin
        nmis++;
        $display("FAIL reset_abort cyc%0d: got %h want %h", i, o[0], exp_q[i]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #1;
      nvec++;
      if (o[0] !== IDLE) begin
        nmis++;
        $display("FAIL reset_hold cyc%0d: got %h want %h", k, o[0], IDLE);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    exp_q = '{FA, FD_L, DEC, WR_L, FA};
    foreach (exp_q[i]) begin
      if (i != 0) @(negedge clock);
      #1;
      nvec++;
      if (o[0] !== exp_q[i]) begin
        nmis++;
        $display("FAIL reset_release cyc%0d: got %h want %h", i, o[0], exp_q[i]);
      end
    end
  endtask

  task automatic test_load;
    logic [16:0] exp_q[$];
    exp_q = '{FA, FD_L, DEC, RD_L, FA};
    restart(OP_LOAD, 1'b0);
    foreach (exp_q[i]) begin
      if (i != 0) @(negedge clock);
      #1;
      nvec++;
      if (o[0] !== exp_q[i]) begin
        nmis++;
        $display("FAIL load_w0 cyc%0d: got %h want %h", i, o[0], exp_q[i]);
      end
    end
  endtask

  task automatic test_add_xor_w2;
    logic [16:0] exp_q[$];
    exp_q = '{FA, FD, FD, FD_L, DEC,
              RD | ALU_ACC | ALU_ADD, RD | ALU_ACC | ALU_ADD, RD_L | ALU_ACC | ALU_ADD,
              FA, FD, FD, FD_L, DEC,
              RD | ALU_ACC | ALU_XOR, RD | ALU_ACC | ALU_XOR, RD_L | ALU_ACC | ALU_XOR,
              FA};
    restart(OP_ADD, 1'b0);
    foreach (exp_q[i]) begin
      if (i != 0) @(negedge clock);
      if (i == 8) op = OP_XOR;
      #1;
      nvec++;
      if (o[2] !== exp_q[i]) begin
        nmis++;
        $display("FAIL add_xor_w2 cyc%0d: got %h want %h", i, o[2], exp_q[i]);
      end
    end
  endtask

  task automatic test_sub_w1;
    logic [16:0] exp_q[$];
    exp_q = '{FA, FD, FD_L, DEC, RD | ALU_ACC | ALU_SUB, RD_L | ALU_ACC | ALU_SUB, FA};
    restart(OP_SUB, 1'b1);
    foreach (exp_q[i]) begin
      if (i != 0) @(negedge clock);
      #1;
      nvec++;
      if (o[1] !== exp_q[i]) begin
        nmis++;
        $display("FAIL sub_w1 cyc%0d: got %h want %h", i, o[1], exp_q[i]);
      end
    end
  endtask

  task automatic test_store_w1;
    logic [16:0] exp_q[$];
    exp_q = '{FA, FD, FD_L, DEC, WR, WR_L, FA};
    restart(OP_STORE, 1'b0);
    foreach (exp_q[i]) begin
      if (i != 0) @(negedge clock);
      #1;
      nvec++;
      if (o[1] !== exp_q[i]) begin
        nmis++;
        $display("FAIL store_w1 cyc%0d: got %h want %h", i, o[1], exp_q[i]);
      end
    end
  endtask

  task automatic test_bne;
    logic [16:0] exp_q[$];
    exp_q = '{FA, FD_L, DEC | LOAD_PC | DONE, FA};
    restart(OP_BNE, 1'b0);
    foreach (exp_q[i]) begin
      if (i != 0) @(negedge clock);
      #1;
      nvec++;
      if (o[0] !== exp_q[i]) begin
        nmis++;
        $display("FAIL bne_z0 cyc%0d: got %h want %h", i, o[0], exp_q[i]);
      end
    end
    exp_q = '{FA, FD_L, DEC | DONE, FA};
    restart(OP_BNE, 1'b1);
    foreach (exp_q[i]) begin
      if (i != 0) @(negedge clock);
      #1;
      nvec++;
      if (o[0] !== exp_q[i]) begin
        nmis++;
        $display("FAIL bne_z1 cyc%0d: got %h want %h", i, o[0], exp_q[i]);
      end
    end
    // z_flag toggles outside DECODE must not matter; DECODE sees z_flag=0.
    exp_q = '{FA, FD, FD_L, DEC | LOAD_PC | DONE, FA};
    restart(OP_BNE, 1'b1);
    foreach (exp_q[i]) begin
      if (i != 0) @(negedge clock);
      if (i == 3) z_flag = 1'b0;
      if (i == 4) z_flag = 1'b1;
      #1;
      nvec++;
      if (o[1] !== exp_q[i]) begin
        nmis++;
        $display("FAIL bne_w1 cyc%0d: got %h want %h", i, o[1], exp_q[i]);
      end
    end
  endtask

  task automatic test_op7;
    logic [16:0] exp_q[$];
`ifdef SEQ_HALT_EN
    exp_q = '{FA, FD_L, DEC | DONE};
    for (int k = 0; k < 20; k++) exp_q.push_back(IDLE);
`else
    exp_q = '{FA, FD_L, DEC | DONE, FA, FD_L};
`endif
    restart(OP_SEVEN, 1'b0);
    foreach (exp_q[i]) begin
      if (i != 0) @(negedge clock);
      #1;
      nvec++;
      if (o[0] !== exp_q[i]) begin
        nmis++;
        $display("FAIL op7 cyc%0d: got %h want %h", i, o[0], exp_q[i]);
      end
    end
    restart(OP_LOAD, 1'b0);
    #1;
    nvec++;
    if (o[0] !== FA) begin
      nmis++;
      $display("FAIL op7_restart: got %h want %h", o[0], FA);
    end
  endtask

  initial begin
    reset  = 1'b1;
    op     = OP_LOAD;
    z_flag = 1'b0;
    test_reset();
    test_load();
    test_add_xor_w2();
    test_sub_w1();
    test_store_w1();
    test_bne();
    test_op7();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Control-unit FSM for the basic accumulator processor.
- Drives every load/bus-enable strobe on the shared sysbus: PC, IR, ACC, ALU and the MAR/MDR/CS/R_NW interface of the ROM/RAM.
- Sequences fetch, decode and execute for each instruction, with a programmable number of memory wait states.
- Sits between the IR opcode/ALU Z flag and the datapath registers.

Parameters:
- WORD_W, 8, datapath word width.
- OP_W, 3, opcode field width (IR[WORD_W-1 -: OP_W]).
- WAIT_STATES, 0, extra cycles each memory access holds CS before data is used (0..7).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  OP_W  opcode from IR.
- z_flag  in  1  ACC==0 flag from ALU.
- ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus  out  1 each  datapath strobes.
- ALU_ACC, ALU_add, ALU_sub, ALU_xor  out  1 each  ALU controls.
- load_MAR, load_MDR, MDR_bus, CS  out  1 each  memory strobes.
- R_NW  out  1  1=read, 0=write.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.

Behaviour:
- Opcodes: LOAD=0, STORE=1, ADD=2, SUB=3, BNE=4, XOR=5; 6 is NOP; 7 is HALT only with the optional feature, otherwise NOP.
- States: FETCH_A, FETCH_D, DECODE, EXEC_RD, EXEC_WR, HALT (optional). Outputs are combinational from state, op, z_flag and the wait counter. Any strobe not listed for a state is 0. R_NW defaults to 1.
- Reset: while reset=1, state=FETCH_A, wait counter=0, all outputs 0 and R_NW=1 regardless of state. A reset asserted mid-instruction aborts it; no partial write completes after reset falls.
- FETCH_A: PC_bus, load_MAR, INC_PC, load_PC. Next state is FETCH_D.
- FETCH_D: CS=1, R_NW=1 for WAIT_STATES+1 cycles. MDR_bus and load_IR are asserted only on the final cycle. Next state is DECODE.
- DECODE: Addr_bus, load_MAR.
  - LOAD/ADD/SUB/XOR go to EXEC_RD.
  - STORE goes to EXEC_WR.
  - BNE: when z_flag=0, also assert load_PC (PC takes the address from Addr_bus). Assert instr_done and go to FETCH_A.
  - NOP: assert instr_done and go to FETCH_A.
- EXEC_RD: CS=1, R_NW=1 for WAIT_STATES+1 cycles. Final cycle asserts MDR_bus, load_ACC and instr_done.
  - ALU_ACC=1 for ADD/SUB/XOR, 0 for LOAD (pass-through).
  - Exactly one of ALU_add/ALU_sub/ALU_xor asserted, matching the opcode.
  - Next state is FETCH_A.
- EXEC_WR: ACC_bus, load_MDR, CS=1, R_NW=0 for WAIT_STATES+1 cycles. Final cycle asserts instr_done. Next state is FETCH_A.
- Wait counter: width $clog2(WAIT_STATES+1) (minimum 1). Loads 0 on entry to each memory state and increments while CS=1. The final cycle is counter==WAIT_STATES. With WAIT_STATES=0 every memory state lasts 1 cycle.
- Latency with W=WAIT_STATES:
  - LOAD/ADD/SUB/XOR/STORE: 4+2W cycles.
  - BNE/NOP: 3+W cycles.
- op and z_flag are sampled only in DECODE and EXEC_RD. Changes in other states are ignored.
- Never assert MDR_bus together with ACC_bus or PC_bus or Addr_bus in the same cycle (single bus driver).

Optional Feature:
- SEQ_HALT_EN defined: opcode 7 in DECODE asserts instr_done and enters HALT. HALT drives all outputs 0 (R_NW=1) and is exited only by reset.
- SEQ_HALT_EN undefined: opcode 7 is a NOP and the HALT state is not compiled.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode_t enum (values above).
  - state_t enum.
  - Constants WORD_W_DEF and OP_W_DEF.
- Opcode values must stay identical to the existing opcode header.
- One sub-module: seq_wait_counter (parameter WAIT_STATES; inputs clock, reset, clear, enable; output last).

Test Plan:
- Reset held 3 cycles mid EXEC_WR with W=0 -> all strobes 0, R_NW=1. First cycle after release is FETCH_A: PC_bus=load_MAR=INC_PC=1.
- op=LOAD, W=0 -> strobe sequence FETCH_A, FETCH_D(load_IR), DECODE(load_MAR), EXEC_RD(MDR_bus, load_ACC, ALU_ACC=0). instr_done high in cycle 4 only.
- op=ADD then op=XOR, W=2 -> each takes 8 cycles. In EXEC_RD, load_ACC appears only on the 3rd cycle, with ALU_add, then ALU_xor. CS high all 3 cycles.
- op=STORE, W=1 -> EXEC_WR lasts 2 cycles with R_NW=0, ACC_bus=1, CS=1. MDR_bus stays 0 throughout.
- op=BNE with z_flag=0 -> DECODE asserts load_PC+Addr_bus, 3 cycles total. With z_flag=1 -> load_PC=0, 3 cycles total.
- op=7 -> with SEQ_HALT_EN: outputs frozen at 0 for 20 cycles until reset. Without SEQ_HALT_EN: 3-cycle NOP, then fetch resumes.
